// File: rtl/mdio_key_pkg.sv
// Shared types and constants for the key/poll MDIO sequencer.
// The optional op_done watchdog in mdio_key_ctrl is enabled by defining MDIO_TIMEOUT_EN.
package mdio_key_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_BMCR,
        S_WAIT_WR,
        S_RD_BMSR,
        S_WAIT_BMSR,
        S_RD_PHYSR,
        S_WAIT_PHYSR
    } state_t;

    localparam logic [4:0] REG_BMCR  = 5'd0;
    localparam logic [4:0] REG_BMSR  = 5'd1;
    localparam logic [4:0] REG_PHYSR = 5'd17;

    localparam int BMSR_LINK_BIT = 2;

    localparam logic [1:0] SPD_10   = 2'b00;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_1000 = 2'b10;
    localparam logic [1:0] SPD_RSVD = 2'b11;

    function automatic logic is_wait(input state_t s);
        return (s == S_WAIT_WR) || (s == S_WAIT_BMSR) || (s == S_WAIT_PHYSR);
    endfunction

endpackage

// File: rtl/mdio_key_ctrl_if.sv
// Command handshake between the sequencer (master) and the MDIO frame driver (slave).
interface mdio_key_ctrl_if;
    logic        op_exec;
    logic        op_rh_wr;
    logic [4:0]  op_addr;
    logic [15:0] op_wr_data;
    logic [4:0]  phy_addr;
    logic        op_done;
    logic [15:0] op_rd_data;
    logic        op_rd_ack;

    modport master (
        output op_exec, op_rh_wr, op_addr, op_wr_data, phy_addr,
        input  op_done, op_rd_data, op_rd_ack
    );

    modport slave (
        input  op_exec, op_rh_wr, op_addr, op_wr_data, phy_addr,
        output op_done, op_rd_data, op_rd_ack
    );
endinterface

// File: rtl/mdio_poll_timer.sv
// Idle-time poll counter: counts while enabled, clears on request, pulses expire
// for one cycle on the POLL_CYC-th enabled cycle and restarts from zero.
module mdio_poll_timer #(
    parameter logic [23:0] POLL_CYC = 24'd12_500_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    logic [23:0] cnt;

    assign expire = en && !clr && (cnt == POLL_CYC - 24'd1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            cnt <= '0;
        else if (clr || expire)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 24'd1;
    end

endmodule

// File: rtl/mdio_key_ctrl.sv
// Key-triggered PHY soft reset plus periodic BMSR/PHYSR link/speed polling over the MDIO driver.
// Define MDIO_TIMEOUT_EN to add an op_done watchdog on every WAIT_* state.
module mdio_key_ctrl
    import mdio_key_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR    = 5'b00001,
    parameter logic [23:0] POLL_CYC    = 24'd12_500_000,
    parameter logic [15:0] BMCR_RST    = 16'h9140
`ifdef MDIO_TIMEOUT_EN
    , parameter logic [19:0] TIMEOUT_CYC = 20'd1_000_000
`endif
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               key_filter,
    mdio_key_ctrl_if.master    op,
    output logic               link_up,
    output logic [1:0]         speed,
    output logic               busy,
    output logic               err
);

    state_t state;
    logic   key_d;
    logic   press;
    logic   pending;
    logic   poll_expire;
    logic   wd_hit;

    assign op.phy_addr = PHY_ADDR;
    assign busy        = (state != S_IDLE);
    assign press       = key_d & ~key_filter;

    // One-deep request latch: a press while one is already queued is dropped.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_d   <= 1'b1;
            pending <= 1'b0;
        end else begin
            key_d <= key_filter;
            if (state == S_WR_BMCR)
                pending <= 1'b0;
            else if (press)
                pending <= 1'b1;
        end
    end

    mdio_poll_timer #(.POLL_CYC(POLL_CYC)) u_poll (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (state == S_IDLE),
        .clr       (state != S_IDLE),
        .expire    (poll_expire)
    );

`ifdef MDIO_TIMEOUT_EN
    logic [19:0] wd_cnt;

    assign wd_hit = is_wait(state) && (wd_cnt == TIMEOUT_CYC - 20'd1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            wd_cnt <= '0;
        else if (!is_wait(state) || wd_hit)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 20'd1;
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= S_IDLE;
            op.op_exec    <= 1'b0;
            op.op_rh_wr   <= 1'b1;
            op.op_addr    <= '0;
            op.op_wr_data <= '0;
            link_up       <= 1'b0;
            speed         <= SPD_10;
            err           <= 1'b0;
        end else begin
            op.op_exec <= 1'b0;
            if (wd_hit) begin
                // Driver never answered: abandon the op, status stays as last known.
                err   <= 1'b1;
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (pending)
                            state <= S_WR_BMCR;
                        else if (poll_expire)
                            state <= S_RD_BMSR;
                    end
                    S_WR_BMCR: begin
                        op.op_exec    <= 1'b1;
                        op.op_rh_wr   <= 1'b0;
                        op.op_addr    <= REG_BMCR;
                        op.op_wr_data <= BMCR_RST;
                        state         <= S_WAIT_WR;
                    end
                    S_WAIT_WR: begin
                        if (op.op_done)
                            state <= S_RD_BMSR;
                    end
                    S_RD_BMSR: begin
                        op.op_exec  <= 1'b1;
                        op.op_rh_wr <= 1'b1;
                        op.op_addr  <= REG_BMSR;
                        state       <= S_WAIT_BMSR;
                    end
                    S_WAIT_BMSR: begin
                        if (op.op_done) begin
                            if (op.op_rd_ack) begin
                                err   <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                link_up <= op.op_rd_data[BMSR_LINK_BIT];
                                err     <= 1'b0;
                                state   <= op.op_rd_data[BMSR_LINK_BIT] ? S_RD_PHYSR : S_IDLE;
                            end
                        end
                    end
                    S_RD_PHYSR: begin
                        op.op_exec  <= 1'b1;
                        op.op_rh_wr <= 1'b1;
                        op.op_addr  <= REG_PHYSR;
                        state       <= S_WAIT_PHYSR;
                    end
                    S_WAIT_PHYSR: begin
                        if (op.op_done) begin
                            // The reserved speed code leaves the previous rate in place.
                            if (!op.op_rd_ack && op.op_rd_data[15:14] != SPD_RSVD)
                                speed <= op.op_rd_data[15:14];
                            if (op.op_rd_ack)
                                err <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdio_key_ctrl.sv
// Self-checking bench for mdio_key_ctrl: a randomized-latency driver model answers op_exec,
// and a register-level status model predicts the op sequence and link/speed/err.
module tb_mdio_key_ctrl;

    localparam logic [23:0] POLL     = 24'd100;
    localparam logic [19:0] TMO      = 20'd300;
    localparam logic [15:0] BMCR_VAL = 16'h9140;

    typedef struct packed {
        logic        rh;
        logic [4:0]  addr;
        logic [15:0] wd;
    } op_t;

    localparam op_t OP_W   = {1'b0, 5'd0, 16'h9140};
    localparam op_t OP_R1  = {1'b1, 5'd1, 16'h0000};
    localparam op_t OP_R17 = {1'b1, 5'd17, 16'h0000};
    localparam logic [27:0] RST_OUTS = {1'b0, 1'b1, 5'd0, 16'd0, 1'b0, 2'b00, 1'b0, 1'b0};

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key_filter = 1'b1;
    logic       link_up, busy, err;
    logic [1:0] speed;

    mdio_key_ctrl_if bus();

    mdio_key_ctrl #(
        .PHY_ADDR (5'd1),
        .POLL_CYC (POLL),
        .BMCR_RST (BMCR_VAL)
`ifdef MDIO_TIMEOUT_EN
        , .TIMEOUT_CYC (TMO)
`endif
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_filter (key_filter),
        .op         (bus),
        .link_up    (link_up),
        .speed      (speed),
        .busy       (busy),
        .err        (err)
    );

    always #5 sys_clk = ~sys_clk;

    int vecs = 0;
    int errs = 0;

    // Driver model state
    op_t         ops[$];
    logic [15:0] bmsr_d = '0, physr_d = '0;
    logic        bmsr_a = 1'b0, physr_a = 1'b0;
    bit          hold = 1'b0;
    int          stray_req = 0, stray_done = 0;

    // Status model
    logic       m_link = 1'b0, m_err = 1'b0;
    logic [1:0] m_speed = 2'b00;
    op_t        exp_q[$];

    function automatic logic [27:0] outs();
        return {bus.op_exec, bus.op_rh_wr, bus.op_addr, bus.op_wr_data, link_up, speed, busy, err};
    endfunction

    // One poll: BMSR read, then PHYSR only when the PHY answered with link up.
    function automatic void model_poll(input logic [15:0] bd, input logic ba,
                                       input logic [15:0] pd, input logic pa);
        exp_q.push_back(OP_R1);
        if (ba) m_err = 1'b1;
        else begin
            m_link = bd[2];
            m_err  = 1'b0;
            if (bd[2]) begin
                exp_q.push_back(OP_R17);
                if (pa) m_err = 1'b1;
                else if (pd[15:14] != 2'b11) m_speed = pd[15:14];
            end
        end
    endfunction

    function automatic bit ops_match();
        if (ops.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) begin
            if (ops[i].rh !== exp_q[i].rh || ops[i].addr !== exp_q[i].addr) return 1'b0;
            if (!exp_q[i].rh && ops[i].wd !== exp_q[i].wd) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_busy(input logic lvl, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge sys_clk); #1;
            if (busy === lvl) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_exec(input int lim, output int n);
        n = 0;
        while (n < lim) begin
            @(posedge sys_clk); #1;
            n++;
            if (bus.op_exec === 1'b1) break;
        end
    endtask

    // Driver: answers each op after 3..6 cycles, checking the command stays stable meanwhile.
    initial begin
        op_t cur;
        int  lat;
        bus.op_done = 1'b0; bus.op_rd_data = '0; bus.op_rd_ack = 1'b0;
        forever begin
            @(posedge sys_clk); #1;
            if (sys_rst_n && bus.op_exec === 1'b1) begin
                cur = {bus.op_rh_wr, bus.op_addr, bus.op_wr_data};
                ops.push_back(cur);
                if (!hold) begin
                    lat = $urandom_range(3, 6);
                    for (int i = 0; i < lat; i++) begin
                        @(posedge sys_clk); #1;
                        if (!sys_rst_n) break;
                        vecs++;
                        if ({bus.op_rh_wr, bus.op_addr, bus.op_wr_data} !== cur) begin
                            errs++;
                            $display("FAIL op_stable: got %h want %h",
                                     {bus.op_rh_wr, bus.op_addr, bus.op_wr_data}, cur);
                        end
                    end
                    if (sys_rst_n) begin
                        bus.op_done = 1'b1;
                        if (cur.addr == 5'd1) begin
                            bus.op_rd_data = bmsr_d; bus.op_rd_ack = bmsr_a;
                        end else if (cur.addr == 5'd17) begin
                            bus.op_rd_data = physr_d; bus.op_rd_ack = physr_a;
                        end else begin
                            bus.op_rd_data = 16'($urandom); bus.op_rd_ack = 1'b0;
                        end
                        @(posedge sys_clk); #1;
                        bus.op_done = 1'b0;
                        bus.op_rd_data = 16'($urandom);
                        bus.op_rd_ack = 1'($urandom);
                    end
                end
            end else if (stray_req != stray_done) begin
                bus.op_done = 1'b1; bus.op_rd_ack = 1'b1; bus.op_rd_data = 16'h0004;
                @(posedge sys_clk); #1;
                bus.op_done = 1'b0;
                stray_done++;
            end
        end
    end

    task automatic test_reset();
        int n;
        bit ok;
        sys_rst_n = 1'b0; key_filter = 1'b1; hold = 1'b0;
        bmsr_d = 16'h7969; bmsr_a = 1'b0;
        repeat (3) @(posedge sys_clk); #1;
        vecs++;
        if (outs() !== RST_OUTS) begin errs++; $display("FAIL reset_outs: got %h want %h", outs(), RST_OUTS); end
        vecs++;
        if (bus.phy_addr !== 5'd1) begin errs++; $display("FAIL phy_addr: got %h want 01", bus.phy_addr); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        ops.delete(); exp_q.delete();
        m_link = 1'b0; m_speed = 2'b00; m_err = 1'b0;
        n = 0;
        while (n < int'(POLL) + 20) begin
            @(posedge sys_clk); #1;
            n++;
            if (bus.op_exec === 1'b1) break;
            if (n == 50) begin
                vecs++;
                if (outs() !== RST_OUTS) begin errs++; $display("FAIL idle_outs: got %h want %h", outs(), RST_OUTS); end
            end
        end
        // Edges are numbered from 0 after release; the first poll read issues on edge POLL_CYC.
        vecs++;
        if (n - 1 != int'(POLL)) begin errs++; $display("FAIL first_poll_cycle: got %0d want %0d", n - 1, POLL); end
        vecs++;
        if ({bus.op_rh_wr, bus.op_addr} !== {1'b1, 5'd1}) begin
            errs++; $display("FAIL first_poll_op: got rh=%b addr=%0d want rh=1 addr=1", bus.op_rh_wr, bus.op_addr);
        end
        wait_busy(1'b0, 50, ok);
        model_poll(16'h7969, 1'b0, 16'h0, 1'b0);
        vecs++;
        if (!ok || !ops_match()) begin errs++; $display("FAIL reset_poll_seq: done=%b got %0d ops want %0d", ok, ops.size(), exp_q.size()); end
        vecs++;
        if ({link_up, speed, err} !== {m_link, m_speed, m_err}) begin
            errs++; $display("FAIL reset_poll_status: got %b want %b", {link_up, speed, err}, {m_link, m_speed, m_err});
        end
    endtask

    task automatic test_key_press();
        int n;
        bit ok;
        bmsr_d = 16'h796D; bmsr_a = 1'b0; physr_d = 16'h8000; physr_a = 1'b0;
        ops.delete(); exp_q.delete();
        @(negedge sys_clk);
        key_filter = 1'b0;
        wait_exec(10, n);
        vecs++;
        if (n > 3 || bus.op_exec !== 1'b1) begin errs++; $display("FAIL key_latency: got %0d cycles want <=3", n); end
        vecs++;
        if ({bus.op_rh_wr, bus.op_addr, bus.op_wr_data} !== {1'b0, 5'd0, BMCR_VAL}) begin
            errs++; $display("FAIL key_bmcr_op: got %h want %h", {bus.op_rh_wr, bus.op_addr, bus.op_wr_data}, {1'b0, 5'd0, BMCR_VAL});
        end
        wait_busy(1'b0, 200, ok);
        exp_q.push_back(OP_W);
        model_poll(16'h796D, 1'b0, 16'h8000, 1'b0);
        vecs++;
        if (!ok || !ops_match()) begin errs++; $display("FAIL key_seq: done=%b got %0d ops want %0d", ok, ops.size(), exp_q.size()); end
        vecs++;
        if ({link_up, speed, err, busy} !== {m_link, m_speed, m_err, 1'b0}) begin
            errs++; $display("FAIL key_status: got %b want %b", {link_up, speed, err, busy}, {m_link, m_speed, m_err, 1'b0});
        end
        key_filter = 1'b1;
    endtask

    task automatic test_link_status();
        logic [15:0] bd, pd;
        logic        ba, pa;
        bit          ok1, ok2;
        for (int k = 0; k < 14; k++) begin
            case (k)
                0: begin bd = 16'h7969; ba = 1'b0; pd = 16'h0000; pa = 1'b0; end
                1: begin bd = 16'h796D; ba = 1'b0; pd = 16'h4000; pa = 1'b0; end
                2: begin bd = 16'h796D; ba = 1'b1; pd = 16'h8000; pa = 1'b0; end
                3: begin bd = 16'h796D; ba = 1'b0; pd = 16'hC000; pa = 1'b0; end
                4: begin bd = 16'h796D; ba = 1'b0; pd = 16'h0000; pa = 1'b1; end
                5: begin bd = 16'h796D; ba = 1'b0; pd = 16'h0000; pa = 1'b0; end
                default: begin
                    bd = 16'($urandom); ba = ($urandom_range(0, 3) == 0);
                    pd = 16'($urandom); pa = ($urandom_range(0, 4) == 0);
                end
            endcase
            bmsr_d = bd; bmsr_a = ba; physr_d = pd; physr_a = pa;
            ops.delete(); exp_q.delete();
            wait_busy(1'b1, int'(POLL) + 10, ok1);
            wait_busy(1'b0, 100, ok2);
            model_poll(bd, ba, pd, pa);
            vecs++;
            if (!ok1 || !ok2 || !ops_match()) begin
                errs++; $display("FAIL poll_seq[%0d]: done=%b%b got %0d ops want %0d", k, ok1, ok2, ops.size(), exp_q.size());
            end
            vecs++;
            if ({link_up, speed, err} !== {m_link, m_speed, m_err}) begin
                errs++; $display("FAIL poll_status[%0d]: got %b want %b", k, {link_up, speed, err}, {m_link, m_speed, m_err});
            end
        end
    endtask

    task automatic test_same_cycle();
        int n, t;
        bit ok1, ok2;
        bmsr_d = 16'h7969; bmsr_a = 1'b0;
        wait_busy(1'b1, int'(POLL) + 10, ok1);
        wait_busy(1'b0, 100, ok2);
        model_poll(16'h7969, 1'b0, 16'h0, 1'b0);
        ops.delete(); exp_q.delete();
        // Idle began at the edge just seen; land the press on the same edge the poll expires.
        repeat (int'(POLL) - 2) @(posedge sys_clk);
        #1 key_filter = 1'b0;
        wait_exec(10, n);
        vecs++;
        if (bus.op_exec !== 1'b1 || bus.op_rh_wr !== 1'b0 || bus.op_addr !== 5'd0) begin
            errs++; $display("FAIL press_vs_poll: got exec=%b rh=%b addr=%0d want exec=1 rh=0 addr=0", bus.op_exec, bus.op_rh_wr, bus.op_addr);
        end
        key_filter = 1'b1;
        @(posedge sys_clk); #1;
        key_filter = 1'b0;
        t = 0;
        while (t < 300 && !(ops.size() >= 4 && busy === 1'b0)) begin
            @(posedge sys_clk); #1;
            t++;
        end
        repeat (30) @(posedge sys_clk); #1;
        exp_q.push_back(OP_W);
        model_poll(16'h7969, 1'b0, 16'h0, 1'b0);
        exp_q.push_back(OP_W);
        model_poll(16'h7969, 1'b0, 16'h0, 1'b0);
        vecs++;
        if (!ok1 || !ok2 || t >= 300 || !ops_match()) begin
            errs++; $display("FAIL second_press_seq: got %0d ops want %0d", ops.size(), exp_q.size());
        end
        vecs++;
        if ({link_up, speed, err, busy} !== {m_link, m_speed, m_err, 1'b0}) begin
            errs++; $display("FAIL second_press_status: got %b want %b", {link_up, speed, err, busy}, {m_link, m_speed, m_err, 1'b0});
        end
        key_filter = 1'b1;
    endtask

    task automatic test_stray_done();
        int t;
        ops.delete();
        stray_req++;
        t = 0;
        while (t < 10 && stray_done != stray_req) begin
            @(posedge sys_clk); #1;
            t++;
        end
        repeat (2) @(posedge sys_clk); #1;
        vecs++;
        if (t >= 10 || {err, busy, link_up, speed} !== {m_err, 1'b0, m_link, m_speed} || ops.size() != 0) begin
            errs++; $display("FAIL stray_done: got err=%b busy=%b ops=%0d want err=%b busy=0 ops=0", err, busy, ops.size(), m_err);
        end
    endtask

    task automatic test_reset_mid_op();
        int n;
        bit ok;
        hold = 1'b1;
        @(negedge sys_clk);
        key_filter = 1'b0;
        wait_busy(1'b1, 10, ok);
        repeat (3) @(posedge sys_clk); #1;
        vecs++;
        if (!ok || busy !== 1'b1) begin errs++; $display("FAIL mid_op_busy: got %b want 1", busy); end
        sys_rst_n = 1'b0;
        #1;
        vecs++;
        if (outs() !== RST_OUTS) begin errs++; $display("FAIL mid_op_reset_outs: got %h want %h", outs(), RST_OUTS); end
        key_filter = 1'b1;
        hold = 1'b0;
        bmsr_d = 16'h796D; bmsr_a = 1'b0; physr_d = 16'h4000; physr_a = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        ops.delete(); exp_q.delete();
        m_link = 1'b0; m_speed = 2'b00; m_err = 1'b0;
        wait_exec(int'(POLL) + 20, n);
        vecs++;
        if (n - 1 != int'(POLL) || bus.op_rh_wr !== 1'b1 || bus.op_addr !== 5'd1) begin
            errs++; $display("FAIL post_reset_first_op: got cycle=%0d rh=%b addr=%0d want cycle=%0d rh=1 addr=1", n - 1, bus.op_rh_wr, bus.op_addr, POLL);
        end
        wait_busy(1'b0, 100, ok);
        model_poll(16'h796D, 1'b0, 16'h4000, 1'b0);
        vecs++;
        if (!ok || !ops_match() || {link_up, speed, err} !== {m_link, m_speed, m_err}) begin
            errs++; $display("FAIL post_reset_poll: got %b ops=%0d want %b ops=%0d", {link_up, speed, err}, ops.size(), {m_link, m_speed, m_err}, exp_q.size());
        end
    endtask

`ifdef MDIO_TIMEOUT_EN
    task automatic test_timeout();
        int t;
        bit ok;
        hold = 1'b1;
        wait_busy(1'b1, int'(POLL) + 10, ok);
        t = 0;
        while (t < int'(TMO) + 20 && busy !== 1'b0) begin
            @(posedge sys_clk); #1;
            t++;
        end
        m_err = 1'b1;
        vecs++;
        if (!ok || t < int'(TMO) || t > int'(TMO) + 2) begin
            errs++; $display("FAIL timeout_len: got %0d cycles want %0d..%0d", t, TMO, TMO + 2);
        end
        vecs++;
        if ({link_up, speed, err} !== {m_link, m_speed, m_err}) begin
            errs++; $display("FAIL timeout_status: got %b want %b", {link_up, speed, err}, {m_link, m_speed, m_err});
        end
        hold = 1'b0;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        test_reset();
        test_key_press();
        test_link_status();
        test_same_cycle();
        test_stray_done();
        test_reset_mid_op();
`ifdef MDIO_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
